// File: rtl/ddr3_host_arbiter.sv
// ddr3_host_arbiter
//   Merges two independent requesters onto the single host interface of
//   ddr3_controller. The arbiter issues requests with a zero-cycle
//   combinational accept and round-robin arbitration between the ports.
//   It keeps outstanding reads in an in-order tag FIFO, and uses that FIFO
//   to steer each returned word back to the port that issued the read.
//
//   Optional build macro:
//     HOST_ARB_FIXED_PRIO_EN  - when defined, port 0 always wins a tie and
//                               no round-robin pointer is built.
//
//   Ports
//     clk, reset                 : single clock, synchronous active-high reset
//     pN_valid/cmd/addr/sz/op/din: request from port N (N = 0, 1)
//     pN_accept                  : request taken this cycle (combinational)
//     pN_rvalid/rdata/raddr      : return word offered to port N
//     pN_rread                   : port N consumes the return word
//     ctl_ready, ctl_notfull     : controller flow control
//     ctl_validout/dout/raddr    : controller return path
//     ctl_cmd/addr/sz/op/din     : controller host request inputs
//     ctl_read                   : controller return pop
//     tag_count                  : number of reads currently outstanding
module ddr3_host_arbiter #(
    parameter int TAG_DEPTH_P2 = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    p0_valid,
    input  logic [2:0]              p0_cmd,
    input  logic [25:0]             p0_addr,
    input  logic [1:0]              p0_sz,
    input  logic [2:0]              p0_op,
    input  logic [15:0]             p0_din,
    output logic                    p0_accept,
    output logic                    p0_rvalid,
    output logic [15:0]             p0_rdata,
    output logic [25:0]             p0_raddr,
    input  logic                    p0_rread,
    input  logic                    p1_valid,
    input  logic [2:0]              p1_cmd,
    input  logic [25:0]             p1_addr,
    input  logic [1:0]              p1_sz,
    input  logic [2:0]              p1_op,
    input  logic [15:0]             p1_din,
    output logic                    p1_accept,
    output logic                    p1_rvalid,
    output logic [15:0]             p1_rdata,
    output logic [25:0]             p1_raddr,
    input  logic                    p1_rread,
    input  logic                    ctl_ready,
    input  logic                    ctl_notfull,
    input  logic                    ctl_validout,
    input  logic [15:0]             ctl_dout,
    input  logic [25:0]             ctl_raddr,
    output logic [2:0]              ctl_cmd,
    output logic [25:0]             ctl_addr,
    output logic [1:0]              ctl_sz,
    output logic [2:0]              ctl_op,
    output logic [15:0]             ctl_din,
    output logic                    ctl_read,
    output logic [TAG_DEPTH_P2:0]   tag_count
);

    localparam int         DEPTH   = 1 << TAG_DEPTH_P2;
    localparam logic [2:0] CMD_SCR = 3'b001;
    localparam logic [2:0] CMD_SCW = 3'b010;

    // Per-port views so the port logic can be generated once.
    logic [1:0]  valid;
    logic [1:0]  rread;
    logic [1:0]  accept;
    logic [1:0]  rvalid;
    logic [2:0]  cmd  [2];
    logic [25:0] addr [2];
    logic [1:0]  sz   [2];
    logic [2:0]  op   [2];
    logic [15:0] din  [2];

    assign valid   = {p1_valid, p0_valid};
    assign rread   = {p1_rread, p0_rread};
    assign cmd[0]  = p0_cmd;
    assign cmd[1]  = p1_cmd;
    assign addr[0] = p0_addr;
    assign addr[1] = p1_addr;
    assign sz[0]   = p0_sz;
    assign sz[1]   = p1_sz;
    assign op[0]   = p0_op;
    assign op[1]   = p1_op;
    assign din[0]  = p0_din;
    assign din[1]  = p1_din;

    assign p0_accept = accept[0];
    assign p1_accept = accept[1];
    assign p0_rvalid = rvalid[0];
    assign p1_rvalid = rvalid[1];
    assign p0_rdata  = ctl_dout;
    assign p1_rdata  = ctl_dout;
    assign p0_raddr  = ctl_raddr;
    assign p1_raddr  = ctl_raddr;

    // Tag FIFO state; each entry is {port, sz}.
    logic [2:0]              tag_mem [DEPTH];
    logic [TAG_DEPTH_P2-1:0] wr_ptr_reg;
    logic [TAG_DEPTH_P2-1:0] rd_ptr_reg;
    logic [TAG_DEPTH_P2:0]   count_reg;
    logic [1:0]              beat_reg;
    logic                    tag_full;
    logic                    tag_empty;
    logic                    head_port;
    logic [1:0]              head_sz;

    assign tag_full  = (count_reg == (TAG_DEPTH_P2+1)'(DEPTH));
    assign tag_empty = (count_reg == '0);
    assign head_port = tag_mem[rd_ptr_reg][2];
    assign head_sz   = tag_mem[rd_ptr_reg][1:0];
    assign tag_count = count_reg;

    logic [1:0] is_scr;
    logic [1:0] is_inval;
    logic [1:0] elig;
    logic       grant_vld;
    logic       grant_port;
    logic       rr_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic is_scw;
            assign is_scr[gi] = valid[gi] && (cmd[gi] == CMD_SCR);
            assign is_scw     = valid[gi] && (cmd[gi] == CMD_SCW);
            // Unknown codes are swallowed immediately so the port cannot stall.
            assign is_inval[gi] = !reset && valid[gi] && !is_scr[gi] && !is_scw;
            // Full is taken from the registered count, so a pop in the same
            // cycle does not unblock a read until the following cycle.
            assign elig[gi] = !reset && ctl_ready && ctl_notfull &&
                              (is_scw || (is_scr[gi] && !tag_full));
            assign accept[gi] = (grant_vld && (grant_port == 1'(gi))) || is_inval[gi];
            assign rvalid[gi] = !reset && ctl_validout && !tag_empty &&
                                (head_port == 1'(gi));
        end
    endgenerate

`ifdef HOST_ARB_FIXED_PRIO_EN
    assign rr_sel = 1'b0;
`else
    logic rr_ptr_reg;
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg <= 1'b0;
        end else if (grant_vld) begin
            rr_ptr_reg <= !grant_port;
        end
    end
    assign rr_sel = rr_ptr_reg;
`endif

    always_comb begin
        grant_vld  = |elig;
        grant_port = 1'b0;
        if (elig == 2'b11) begin
            grant_port = rr_sel;
        end else begin
            grant_port = !elig[0];
        end
    end

    always_comb begin
        ctl_cmd  = 3'b000;
        ctl_addr = '0;
        ctl_sz   = '0;
        ctl_op   = '0;
        ctl_din  = '0;
        if (grant_vld) begin
            ctl_cmd  = cmd[grant_port];
            ctl_addr = addr[grant_port];
            ctl_sz   = sz[grant_port];
            ctl_op   = op[grant_port];
            ctl_din  = din[grant_port];
        end
    end

    logic push;
    logic pop;
    assign push     = grant_vld && is_scr[grant_port];
    assign ctl_read = |(rvalid & rread);
    // Last beat of the head read retires its tag.
    assign pop      = ctl_read && (beat_reg == head_sz);

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= {grant_port, sz[grant_port]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            beat_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (ctl_read) begin
                beat_reg <= pop ? 2'b00 : beat_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_host_arbiter.sv
module tb_ddr3_host_arbiter;

    localparam int P2    = 5;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p1_valid;
    logic [2:0]  p0_cmd, p1_cmd, p0_op, p1_op;
    logic [25:0] p0_addr, p1_addr;
    logic [1:0]  p0_sz, p1_sz;
    logic [15:0] p0_din, p1_din;
    logic        p0_accept, p1_accept, p0_rvalid, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic [25:0] p0_raddr, p1_raddr;
    logic        p0_rread, p1_rread;
    logic        ctl_ready, ctl_notfull, ctl_validout;
    logic [15:0] ctl_dout;
    logic [25:0] ctl_raddr;
    logic [2:0]  ctl_cmd, ctl_op;
    logic [25:0] ctl_addr;
    logic [1:0]  ctl_sz;
    logic [15:0] ctl_din;
    logic        ctl_read;
    logic [P2:0] tag_count;

    always #5 clk = ~clk;

    ddr3_host_arbiter #(.TAG_DEPTH_P2(P2)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_cmd(p0_cmd), .p0_addr(p0_addr), .p0_sz(p0_sz),
        .p0_op(p0_op), .p0_din(p0_din), .p0_accept(p0_accept), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_raddr(p0_raddr), .p0_rread(p0_rread),
        .p1_valid(p1_valid), .p1_cmd(p1_cmd), .p1_addr(p1_addr), .p1_sz(p1_sz),
        .p1_op(p1_op), .p1_din(p1_din), .p1_accept(p1_accept), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_raddr(p1_raddr), .p1_rread(p1_rread),
        .ctl_ready(ctl_ready), .ctl_notfull(ctl_notfull), .ctl_validout(ctl_validout),
        .ctl_dout(ctl_dout), .ctl_raddr(ctl_raddr),
        .ctl_cmd(ctl_cmd), .ctl_addr(ctl_addr), .ctl_sz(ctl_sz), .ctl_op(ctl_op),
        .ctl_din(ctl_din), .ctl_read(ctl_read), .tag_count(tag_count)
    );

    // Reference model: outstanding reads as a queue of (owner, words still due).
    typedef struct packed {
        int port;
        int left;
    } tag_t;
    tag_t tq[$];
    int   rr_m;
    int   errors = 0;
    int   checks = 0;
    int   cyc_no = 0;
    int   acc0_cnt, acc1_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs against the model mid-cycle,
    // then advance the model on the edge.
    task automatic cyc();
        logic        v[2];
        logic [2:0]  c[2];
        logic [25:0] a[2];
        logic [1:0]  s[2];
        logic [2:0]  o[2];
        logic [15:0] d[2];
        logic        rd[2];
        bit          scr[2], scw[2], inv[2], el[2], rv[2];
        bit          full, rdx;
        int          g;
        tag_t        h;
        @(negedge clk);
        v[0] = p0_valid; c[0] = p0_cmd; a[0] = p0_addr; s[0] = p0_sz; o[0] = p0_op; d[0] = p0_din; rd[0] = p0_rread;
        v[1] = p1_valid; c[1] = p1_cmd; a[1] = p1_addr; s[1] = p1_sz; o[1] = p1_op; d[1] = p1_din; rd[1] = p1_rread;
        full = (tq.size() == DEPTH);
        for (int p = 0; p < 2; p++) begin
            scr[p] = v[p] && c[p] == 3'b001;
            scw[p] = v[p] && c[p] == 3'b010;
            inv[p] = v[p] && !scr[p] && !scw[p];
            el[p]  = ctl_ready && ctl_notfull && (scw[p] || (scr[p] && !full));
            rv[p]  = ctl_validout && tq.size() > 0 && tq[0].port == p;
        end
        if (el[0] && el[1]) begin
`ifdef HOST_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = rr_m;
`endif
        end else if (el[0]) g = 0;
        else if (el[1]) g = 1;
        else g = -1;
        rdx = (rv[0] && rd[0]) || (rv[1] && rd[1]);
        chk("p0_accept", 32'(p0_accept), 32'((g == 0) || inv[0]));
        chk("p1_accept", 32'(p1_accept), 32'((g == 1) || inv[1]));
        chk("ctl_cmd",  32'(ctl_cmd),  (g >= 0) ? 32'(c[g]) : 32'd0);
        chk("ctl_addr", 32'(ctl_addr), (g >= 0) ? 32'(a[g]) : 32'd0);
        chk("ctl_sz",   32'(ctl_sz),   (g >= 0) ? 32'(s[g]) : 32'd0);
        chk("ctl_op",   32'(ctl_op),   (g >= 0) ? 32'(o[g]) : 32'd0);
        chk("ctl_din",  32'(ctl_din),  (g >= 0) ? 32'(d[g]) : 32'd0);
        chk("p0_rvalid", 32'(p0_rvalid), 32'(rv[0]));
        chk("p1_rvalid", 32'(p1_rvalid), 32'(rv[1]));
        chk("ctl_read",  32'(ctl_read),  32'(rdx));
        chk("p0_rdata",  32'(p0_rdata),  32'(ctl_dout));
        chk("p1_raddr",  32'(p1_raddr),  32'(ctl_raddr));
        chk("tag_count", 32'(tag_count), 32'(tq.size()));
        acc0_cnt += int'(p0_accept);
        acc1_cnt += int'(p1_accept);
        $display("cyc %0d acc=%b%b cmd=%0d rv=%b%b rd=%b tags=%0d",
                 cyc_no, p1_accept, p0_accept, ctl_cmd, p1_rvalid, p0_rvalid, ctl_read, tag_count);
        cyc_no++;
        @(posedge clk);
        if (rdx) begin
            h = tq[0];
            h.left = h.left - 1;
            if (h.left == 0) void'(tq.pop_front());
            else tq[0] = h;
        end
        if (g >= 0 && scr[g]) tq.push_back('{port: g, left: int'(s[g]) + 1});
        if (g >= 0) rr_m = 1 - g;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_p0_accept", 32'(p0_accept), 32'd0);
        chk("rst_p1_accept", 32'(p1_accept), 32'd0);
        chk("rst_ctl_cmd",   32'(ctl_cmd),   32'd0);
        chk("rst_rvalid",    32'({p1_rvalid, p0_rvalid}), 32'd0);
        chk("rst_ctl_read",  32'(ctl_read),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tq.delete();
        rr_m = 0;
    endtask

    task automatic idle_ports();
        p0_valid = 0; p1_valid = 0; p0_rread = 0; p1_rread = 0;
        ctl_validout = 0;
    endtask

    initial begin
        reset = 1; p0_valid = 0; p1_valid = 0; p0_cmd = 0; p1_cmd = 0;
        p0_addr = 0; p1_addr = 0; p0_sz = 0; p1_sz = 0; p0_op = 0; p1_op = 0;
        p0_din = 0; p1_din = 0; p0_rread = 0; p1_rread = 0;
        ctl_ready = 1; ctl_notfull = 1; ctl_validout = 0; ctl_dout = 0; ctl_raddr = 0;
        rr_m = 0;
        do_reset();
        cyc();
        chk("tag_count_after_reset", 32'(tag_count), 32'd0);

        // Both ports write continuously.
        acc0_cnt = 0; acc1_cnt = 0;
        p0_valid = 1; p0_cmd = 3'b010; p0_addr = 26'h11; p0_din = 16'hAAAA; p0_op = 3'd1;
        p1_valid = 1; p1_cmd = 3'b010; p1_addr = 26'h22; p1_din = 16'h5555; p1_op = 3'd2;
        for (int i = 0; i < 4; i++) cyc();
`ifdef HOST_ARB_FIXED_PRIO_EN
        chk("scw_p0_count", 32'(acc0_cnt), 32'd4);
        chk("scw_p1_count", 32'(acc1_cnt), 32'd0);
`else
        chk("scw_p0_count", 32'(acc0_cnt), 32'd2);
        chk("scw_p1_count", 32'(acc1_cnt), 32'd2);
`endif

        // Two reads from different ports, then their returns.
        idle_ports();
        p0_valid = 1; p0_cmd = 3'b001; p0_addr = 26'h100; p0_sz = 2'd1;
        cyc();
        p0_valid = 0;
        p1_valid = 1; p1_cmd = 3'b001; p1_addr = 26'h200; p1_sz = 2'd0;
        cyc();
        p1_valid = 0;
        chk("two_reads_out", 32'(tag_count), 32'd2);
        ctl_validout = 1; p0_rread = 1; p1_rread = 1;
        for (int i = 0; i < 3; i++) begin
            ctl_dout = 16'(16'hD000 + i);
            ctl_raddr = (i < 2) ? 26'(26'h100 + i) : 26'h200;
            cyc();
        end
        chk("reads_drained", 32'(tag_count), 32'd0);
        cyc();  // return valid with no tags: nothing steered

        // Controller back-pressure.
        idle_ports();
        p0_valid = 1; p0_cmd = 3'b010; p1_valid = 1; p1_cmd = 3'b010;
        ctl_notfull = 0;
        for (int i = 0; i < 3; i++) cyc();
        ctl_notfull = 1;
        cyc();

        // Fill the tag FIFO.
        idle_ports();
        p0_cmd = 3'b001; p0_sz = 2'd0;
        for (int i = 0; i < DEPTH; i++) begin
            p0_valid = 1; p0_addr = 26'(i);
            cyc();
        end
        chk("fifo_full_count", 32'(tag_count), 32'd32);
        p1_valid = 1; p1_cmd = 3'b010; p1_addr = 26'h3FF;
        cyc();
        chk("full_scr_held", 32'(tag_count), 32'd32);
        p1_valid = 0;
        ctl_validout = 1; p0_rread = 1;
        cyc();   // pop while full: read still held
        ctl_validout = 0;
        cyc();   // read issues now
        p0_valid = 0;
        ctl_validout = 1;
        for (int i = 0; i < DEPTH + 1; i++) cyc();
        chk("fifo_drained", 32'(tag_count), 32'd0);

        // Invalid command codes.
        idle_ports();
        p0_valid = 1; p0_cmd = 3'b111;
        cyc();
        p1_valid = 1; p1_cmd = 3'b000;
        cyc();
        p1_cmd = 3'b010;
        cyc();

        // Reset with reads outstanding and mid-burst.
        idle_ports();
        p0_cmd = 3'b001; p0_sz = 2'd3;
        for (int i = 0; i < 5; i++) begin
            p0_valid = 1; p0_addr = 26'(26'h40 + i);
            cyc();
        end
        p0_valid = 0;
        ctl_validout = 1; p0_rread = 1;
        cyc();
        chk("pre_reset_tags", 32'(tag_count), 32'd5);
        do_reset();
        p0_rread = 1; ctl_validout = 1;
        cyc();
        chk("post_reset_tags", 32'(tag_count), 32'd0);
        idle_ports();
        p0_valid = 1; p0_cmd = 3'b010; p1_valid = 1; p1_cmd = 3'b010;
        cyc();
        chk("post_reset_rr_p0", 32'(acc0_cnt > 0), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int r0, r1;
            r0 = $urandom_range(0, 7);
            r1 = $urandom_range(0, 7);
            p0_valid = 1'($urandom_range(0, 1));
            p1_valid = 1'($urandom_range(0, 1));
            p0_cmd = (r0 < 3) ? 3'b001 : (r0 < 6) ? 3'b010 : 3'($urandom);
            p1_cmd = (r1 < 3) ? 3'b001 : (r1 < 6) ? 3'b010 : 3'($urandom);
            p0_addr = 26'($urandom); p1_addr = 26'($urandom);
            p0_sz = 2'($urandom); p1_sz = 2'($urandom);
            p0_op = 3'($urandom); p1_op = 3'($urandom);
            p0_din = 16'($urandom); p1_din = 16'($urandom);
            ctl_ready = ($urandom_range(0, 7) != 0);
            ctl_notfull = ($urandom_range(0, 7) != 0);
            ctl_validout = 1'($urandom_range(0, 1));
            ctl_dout = 16'($urandom); ctl_raddr = 26'($urandom);
            p0_rread = 1'($urandom_range(0, 1));
            p1_rread = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
